// File: rtl/trig_receiver.sv
// rtl/trig_receiver.sv - trigger receiver: sync, edge accept, period/missing tracking, armed acquisition window
module trig_receiver #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16,
    parameter int HOLDOFF     = 2,
    parameter int TIMEOUT     = 16,
    parameter int ACQ_LEN     = 8
) (
    input  logic             clk_1_4,
    input  logic             rst_n,
    input  logic             trig_in,
    input  logic             pc_enable,
    input  logic             arm,
    output logic             trig_pulse,
    output logic [CNT_W-1:0] trig_count,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             missing,
    output logic             acq_active,
    output logic             acq_start,
    output logic             acq_done,
    output logic             overrun
);

    // Counter widths; both kept at least one bit so degenerate parameters still elaborate.
    localparam int HO_W  = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
    localparam int ACQ_W = (ACQ_LEN > 1) ? $clog2(ACQ_LEN) : 1;

    localparam logic [CNT_W-1:0] GAP_MAX     = '1;
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
    localparam logic [HO_W-1:0]  HOLDOFF_CNT = HO_W'(HOLDOFF);
    localparam logic [ACQ_W-1:0] ACQ_LAST    = ACQ_W'(ACQ_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_ACQ   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Synchroniser and edge detector
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   prev_q;
    logic                   rise;
    logic                   accept;

    // Trigger pulse and holdoff
    logic                   pulse_q;
    logic                   pulse_d;
    logic                   pulse;
    logic [HO_W-1:0]        holdoff_q;
    logic [HO_W-1:0]        holdoff_d;

    // Measurement
    logic [CNT_W-1:0]       count_q;
    logic [CNT_W-1:0]       count_d;
    logic [CNT_W-1:0]       gap_q;
    logic [CNT_W-1:0]       gap_d;
    logic [CNT_W-1:0]       period_q;
    logic [CNT_W-1:0]       period_d;
    logic                   seen_q;
    logic                   seen_d;
    logic                   pvalid_q;
    logic                   pvalid_d;

    // Acquisition
    state_t                 state_q;
    state_t                 state_d;
    logic [ACQ_W-1:0]       acq_cnt_q;
    logic [ACQ_W-1:0]       acq_cnt_d;
    logic                   overrun_q;
    logic                   overrun_d;

    // New sample enters at stage 0 and walks toward the last stage.
    assign sync_d = {sync_q[SYNC_STAGES-2:0], trig_in};
    assign rise   = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign accept = rise & ~pc_enable & (holdoff_q == '0);

    // A pulse registered just before the PC takes control must not leak out.
    assign pulse  = pulse_q & ~pc_enable;

    // Synchroniser chain plus the previous value of its last stage
    always_ff @(posedge clk_1_4 or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // Pulse register and holdoff countdown; holdoff starts with the pulse so rises in the next HOLDOFF cycles drop
    always_comb begin
        pulse_d   = accept;
        holdoff_d = holdoff_q;
        if (accept) begin
            holdoff_d = HOLDOFF_CNT;
        end else if (holdoff_q != '0) begin
            holdoff_d = holdoff_q - HO_W'(1);
        end
    end

    // Pulse and holdoff state
    always_ff @(posedge clk_1_4 or negedge rst_n) begin
        if (!rst_n) begin
            pulse_q   <= 1'b0;
            holdoff_q <= '0;
        end else begin
            pulse_q   <= pulse_d;
            holdoff_q <= holdoff_d;
        end
    end

    // Trigger count, gap/period measurement and validity flags
    always_comb begin
        count_d  = count_q;
        period_d = period_q;
        gap_d    = gap_q;
        seen_d   = seen_q;
        pvalid_d = pvalid_q;
        if (pulse) begin
            count_d  = count_q + CNT_W'(1);
            period_d = gap_q;
            gap_d    = CNT_W'(1);
        end else if (!pc_enable && (gap_q != GAP_MAX)) begin
            gap_d = gap_q + CNT_W'(1);
        end
        if (pc_enable) begin
            seen_d   = 1'b0;
            pvalid_d = 1'b0;
        end else if (pulse) begin
            seen_d = 1'b1;
            if (seen_q) begin
                pvalid_d = 1'b1;
            end
        end
    end

    // Measurement registers
    always_ff @(posedge clk_1_4 or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= '0;
            period_q <= '0;
            gap_q    <= '0;
            seen_q   <= 1'b0;
            pvalid_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            period_q <= period_d;
            gap_q    <= gap_d;
            seen_q   <= seen_d;
            pvalid_q <= pvalid_d;
        end
    end

    // Acquisition state register
    always_ff @(posedge clk_1_4 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Acquisition next state: arm from IDLE, first pulse opens the window, PC control aborts it
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (arm) begin
                    state_d = S_ARMED;
                end
            end
            S_ARMED: begin
                if (pc_enable) begin
                    state_d = S_IDLE;
                end else if (pulse) begin
                    state_d = S_ACQ;
                end
            end
            S_ACQ: begin
                if (pc_enable) begin
                    state_d = S_IDLE;
                end else if (acq_cnt_q == ACQ_LAST) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Window cycle counter: runs only while staying in ACQ, zero on entry
    always_comb begin
        acq_cnt_d = '0;
        if ((state_q == S_ACQ) && (state_d == S_ACQ)) begin
            acq_cnt_d = acq_cnt_q + ACQ_W'(1);
        end
    end

    // Window counter register
    always_ff @(posedge clk_1_4 or negedge rst_n) begin
        if (!rst_n) begin
            acq_cnt_q <= '0;
        end else begin
            acq_cnt_q <= acq_cnt_d;
        end
    end

    // Acquisition outputs decoded from state so reset closes the window at once
    always_comb begin
        acq_active = 1'b0;
        acq_start  = 1'b0;
        acq_done   = 1'b0;
        case (state_q)
            S_ACQ: begin
                acq_active = 1'b1;
                acq_start  = (acq_cnt_q == '0);
            end
            S_DONE: begin
                acq_done = 1'b1;
            end
            default: begin
                acq_active = 1'b0;
            end
        endcase
    end

    // Overrun: sticky on a pulse inside the window, cleared by an arm taken in IDLE
    always_comb begin
        overrun_d = overrun_q;
        if ((state_q == S_IDLE) && arm) begin
            overrun_d = 1'b0;
        end else if (pulse && (state_q == S_ACQ)) begin
            overrun_d = 1'b1;
        end
    end

    // Overrun register
    always_ff @(posedge clk_1_4 or negedge rst_n) begin
        if (!rst_n) begin
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= overrun_d;
        end
    end

    assign trig_pulse   = pulse;
    assign trig_count   = count_q;
    assign period       = period_q;
    assign period_valid = pvalid_q;
    assign missing      = seen_q & ~pc_enable & ~pulse & (gap_q > TIMEOUT_CNT);
    assign overrun      = overrun_q;

endmodule
